// File: rtl/fs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fs_pkg
// Brief   : Shared types and constants for the filesystem request engine.
// Revision: 1.0 - initial release
// ============================================================================
package fs_pkg;

  localparam int FS_WORD_W = 32;

  typedef enum logic [1:0] {
    FS_OPEN   = 2'd0,
    FS_READ   = 2'd1,
    FS_WRITE  = 2'd2,
    FS_DELETE = 2'd3
  } fs_op_t;

  typedef logic [2:0] fs_state_t;

  localparam fs_state_t c_st_idle  = 3'd0;
  localparam fs_state_t c_st_name  = 3'd1;
  localparam fs_state_t c_st_read  = 3'd2;
  localparam fs_state_t c_st_write = 3'd3;
  localparam fs_state_t c_st_del   = 3'd4;
  localparam fs_state_t c_st_drain = 3'd5;
  localparam fs_state_t c_st_done  = 3'd6;

  function automatic logic fs_has_zero_byte(input logic [FS_WORD_W-1:0] w);
    return (w[7:0] == 8'h00) || (w[15:8] == 8'h00) ||
           (w[23:16] == 8'h00) || (w[31:24] == 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fs_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fs_rd_fifo
// Brief   : Two-entry read-data FIFO with valid/ready on both sides.
// Revision: 1.0 - initial release
// ============================================================================
module fs_rd_fifo
  import fs_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push_valid,
  output logic                 o_push_ready,
  input  logic [FS_WORD_W-1:0] i_push_data,
  output logic                 o_pop_valid,
  input  logic                 i_pop_ready,
  output logic [FS_WORD_W-1:0] o_pop_data,
  output logic [1:0]           o_count
);

  logic [FS_WORD_W-1:0] r_mem [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;
  logic                 w_push;
  logic                 w_pop;

  assign o_push_ready = (r_count != 2'd2);
  assign o_pop_valid  = (r_count != 2'd0);
  assign w_push       = i_push_valid & o_push_ready;
  assign w_pop        = o_pop_valid & i_pop_ready;
  assign o_pop_data   = r_mem[r_rd_ptr];
  assign o_count      = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fs_request_engine.sv
`default_nettype none
// ============================================================================
// Module  : fs_request_engine
// Brief   : Filesystem word-interface initiator: OPEN name streaming, READ/WRITE
//           bursts with flow control, DELETE.
// Revision: 1.0 - initial release
// ============================================================================
module fs_request_engine
  import fs_pkg::*;
#(
  parameter int NAME_BYTES = 32,
  parameter int LEN_W      = 16
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [NAME_BYTES*8-1:0] cmd_name,
  input  logic [31:0]             cmd_addr,
  input  logic [LEN_W-1:0]        cmd_len,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [31:0]             rd_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [31:0]             wr_data,
  output logic                    done,
  output logic                    err,
  output logic                    busy,
  output logic [FS_WORD_W-1:0]    fs_filename,
  output logic                    fs_rden,
  output logic                    fs_wren,
  output logic                    fs_del,
  output logic [31:0]             fs_address,
  output logic [31:0]             fs_data,
  input  logic [31:0]             fs_q
);

  fs_state_t               r_state;
  logic [NAME_BYTES*8-1:0] r_name;
  logic [31:0]             r_addr;
  logic [LEN_W-1:0]        r_len;
  logic                    r_opened;
  logic                    r_err;
  logic                    r_inflight;
  logic [1:0]              w_fifo_count;
  logic                    w_pop;
  logic                    w_credit;
  logic                    w_unused_push_ready;

  fs_rd_fifo u_rd_fifo (
    .clk          (CLOCK_50),
    .rst_n        (reset_n),
    .i_push_valid (r_inflight),
    .o_push_ready (w_unused_push_ready),
    .i_push_data  (fs_q),
    .o_pop_valid  (rd_valid),
    .i_pop_ready  (rd_ready),
    .o_pop_data   (rd_data),
    .o_count      (w_fifo_count)
  );

  // A word leaving the FIFO this cycle frees its slot, keeping 1 word/cycle.
  assign w_pop    = rd_valid & rd_ready;
  assign w_credit = ({1'b0, w_fifo_count} + {2'b00, r_inflight}) < ({2'b00, w_pop} + 3'd2);

  assign cmd_ready   = (r_state == c_st_idle);
  assign busy        = ~cmd_ready;
  assign done        = (r_state == c_st_done);
  assign err         = done & r_err;
  assign fs_rden     = (r_state == c_st_read) && r_opened && (r_len != '0) && w_credit;
  assign wr_ready    = (r_state == c_st_write) && r_opened && (r_len != '0);
  assign fs_wren     = wr_ready & wr_valid;
  assign fs_del      = (r_state == c_st_del);
  assign fs_filename = (r_state == c_st_name) ? r_name[FS_WORD_W-1:0] : '0;
  assign fs_address  = (fs_rden || fs_wren) ? r_addr : 32'd0;
  assign fs_data     = fs_wren ? wr_data : 32'd0;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= c_st_idle;
      r_name     <= '0;
      r_addr     <= 32'd0;
      r_len      <= '0;
      r_opened   <= 1'b0;
      r_err      <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fs_rden;
      case (r_state)
        c_st_idle: begin
          if (cmd_valid) begin
            r_name <= cmd_name;
            r_addr <= cmd_addr;
            r_len  <= cmd_len;
            r_err  <= 1'b0;
            case (fs_op_t'(cmd_op))
              FS_OPEN:  r_state <= c_st_name;
              FS_READ:  r_state <= c_st_read;
              FS_WRITE: r_state <= c_st_write;
              default:  r_state <= c_st_del;
            endcase
          end
        end
        // Shifting zeros in yields the trailing all-zero word for unterminated names.
        c_st_name: begin
          r_name <= r_name >> FS_WORD_W;
          if (fs_has_zero_byte(r_name[FS_WORD_W-1:0])) begin
            r_opened <= 1'b1;
            r_state  <= c_st_done;
          end
        end
        c_st_read: begin
          if (!r_opened) begin
            r_err   <= 1'b1;
            r_state <= c_st_done;
          end else if (r_len == '0) begin
            r_state <= c_st_done;
          end else if (fs_rden) begin
            r_addr <= r_addr + 32'd1;
            r_len  <= r_len - LEN_W'(1);
            if (r_len == LEN_W'(1)) begin
              r_state <= c_st_drain;
            end
          end
        end
        c_st_drain: begin
          if (!r_inflight && (w_fifo_count == 2'd0)) begin
            r_state <= c_st_done;
          end
        end
        c_st_write: begin
          if (!r_opened) begin
            r_err   <= 1'b1;
            r_state <= c_st_done;
          end else if (r_len == '0) begin
            r_state <= c_st_done;
          end else if (fs_wren) begin
            r_addr <= r_addr + 32'd1;
            r_len  <= r_len - LEN_W'(1);
            if (r_len == LEN_W'(1)) begin
              r_state <= c_st_done;
            end
          end
        end
        c_st_del: begin
          r_opened <= 1'b0;
          r_state  <= c_st_done;
        end
        c_st_done: r_state <= c_st_idle;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fs_request_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_fs_request_engine
// Brief   : Self-checking bench: directed vector table, reset corner case and
//           randomized commands against a behavioural filesystem model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fs_request_engine;
  import fs_pkg::*;

  localparam int NB = 32;
  localparam int NW = NB / 4;
  localparam int LW = 16;

  logic            CLOCK_50 = 1'b0;
  logic            reset_n  = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = 2'd0;
  logic [NB*8-1:0] cmd_name = '0;
  logic [31:0]     cmd_addr = 32'd0;
  logic [LW-1:0]   cmd_len = '0;
  logic            rd_valid, rd_ready;
  logic [31:0]     rd_data;
  logic            wr_valid, wr_ready;
  logic [31:0]     wr_data;
  logic            done, err, busy;
  logic [31:0]     fs_filename;
  logic            fs_rden, fs_wren, fs_del;
  logic [31:0]     fs_address, fs_data, fs_q;

  fs_request_engine #(.NAME_BYTES(NB), .LEN_W(LW)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_name(cmd_name), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .done(done), .err(err), .busy(busy),
    .fs_filename(fs_filename), .fs_rden(fs_rden), .fs_wren(fs_wren), .fs_del(fs_del),
    .fs_address(fs_address), .fs_data(fs_data), .fs_q(fs_q)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;

  // Observed bus activity for the current command.
  logic [31:0] m_rden_a[$], m_rd_d[$], m_wr_a[$], m_wr_d[$], m_fname[$];
  int m_del, m_busy, m_viol, m_cyc, m_first_rden, m_last_rden, m_first_rd;
  int m_rden_tot, m_rd_tot;

  always @(negedge CLOCK_50) begin
    int n;
    m_cyc++;
    if (!reset_n) begin
      m_rden_tot = 0;
      m_rd_tot   = 0;
    end else begin
      n = int'(fs_rden) + int'(fs_wren) + int'(fs_del) + int'(fs_filename != 0);
      if (n > 1) m_viol++;
      if ((m_rden_tot - m_rd_tot) + int'(fs_rden) - int'(rd_valid && rd_ready) > 2) m_viol++;
      if (busy) m_busy++;
      if (fs_rden) begin
        m_rden_a.push_back(fs_address);
        if (m_first_rden < 0) m_first_rden = m_cyc;
        m_last_rden = m_cyc;
        m_rden_tot++;
      end
      if (rd_valid && rd_ready) begin
        m_rd_d.push_back(rd_data);
        if (m_first_rd < 0) m_first_rd = m_cyc;
        m_rd_tot++;
      end
      if (fs_wren) begin
        m_wr_a.push_back(fs_address);
        m_wr_d.push_back(fs_data);
      end
      if (fs_del) m_del++;
      if (fs_filename != 0) m_fname.push_back(fs_filename);
    end
  end

  // Responder (latency 1, returns address*4) plus read/write stream drivers.
  int          rdy_mode = 0;
  int          wgap_mode = 0;
  logic [31:0] wq[$];
  int          widx = 0;

  initial begin
    logic        rp;
    logic [31:0] ra;
    logic        wtog;
    wtog = 1'b0;
    fs_q = 32'd0; rd_ready = 1'b0; wr_valid = 1'b0; wr_data = 32'd0;
    forever begin
      @(negedge CLOCK_50);
      rp = fs_rden;
      ra = fs_address;
      if (wr_valid && wr_ready) widx++;
      @(posedge CLOCK_50);
      #1;
      fs_q = rp ? {ra[29:0], 2'b00} : 32'hDEAD_BEEF;
      case (rdy_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ~rd_ready;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      wtog = ~wtog;
      wr_valid = (widx < wq.size()) &&
                 ((wgap_mode == 0) || ((wgap_mode == 1) && wtog) ||
                  ((wgap_mode == 2) && ($urandom_range(0, 1) == 1)));
      wr_data = (widx < wq.size()) ? wq[widx] : 32'd0;
    end
  end

  // Behavioural model of the engine's externally visible effects.
  bit          mdl_opened = 1'b0;
  logic [31:0] e_rden[$], e_rd[$], e_wa[$], e_wd[$], e_fn[$];
  int          e_del, e_busy;
  logic        e_err;

  task automatic model(input logic [1:0] op, input logic [NB*8-1:0] name,
                       input logic [31:0] addr, input int len);
    logic [31:0] w, a;
    int nw;
    bit term;
    e_rden.delete(); e_rd.delete(); e_wa.delete(); e_wd.delete(); e_fn.delete();
    e_del = 0; e_err = 1'b0; e_busy = -1;
    case (op)
      2'd0: begin
        nw = 0; term = 1'b0;
        for (int i = 0; i < NW && !term; i++) begin
          w = name[32*i +: 32];
          nw++;
          if (w != 0) e_fn.push_back(w);
          for (int b = 0; b < 4; b++) if (w[8*b +: 8] == 8'h00) term = 1'b1;
        end
        if (!term) nw++;
        e_busy = nw + 1;
        mdl_opened = 1'b1;
      end
      2'd1, 2'd2: begin
        if (!mdl_opened) begin
          e_err = 1'b1; e_busy = 2;
        end else if (len == 0) begin
          e_busy = 2;
        end else begin
          for (int i = 0; i < len; i++) begin
            a = addr + 32'(i);
            if (op == 2'd1) begin
              e_rden.push_back(a);
              e_rd.push_back(a * 32'd4);
            end else begin
              e_wa.push_back(a);
              e_wd.push_back(wq[i]);
            end
          end
        end
      end
      default: begin
        e_del = 1; e_busy = 2; mdl_opened = 1'b0;
      end
    endcase
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic chk_q(input string nm, input logic [31:0] got[$], input logic [31:0] exp[$]);
    int idx;
    logic [31:0] g, x;
    idx = -1;
    total++;
    if (got.size() != exp.size()) idx = 0;
    else foreach (exp[i]) if (idx < 0 && got[i] !== exp[i]) idx = i;
    if (idx >= 0) begin
      bad++;
      g = (idx < got.size()) ? got[idx] : 32'd0;
      x = (idx < exp.size()) ? exp[idx] : 32'd0;
      $display("FAIL %s: got %0d words (word%0d=%h) want %0d words (word%0d=%h)",
               nm, got.size(), idx, g, exp.size(), idx, x);
    end
  endtask

  logic got_err;
  bit   timed_out;

  task automatic run_cmd(input logic [1:0] op, input logic [NB*8-1:0] name,
                         input logic [31:0] addr, input int len, input int rmode, input int wmode);
    @(posedge CLOCK_50); #1;
    m_rden_a.delete(); m_rd_d.delete(); m_wr_a.delete(); m_wr_d.delete(); m_fname.delete();
    m_del = 0; m_busy = 0; m_viol = 0; m_first_rden = -1; m_last_rden = -1; m_first_rd = -1;
    rdy_mode = rmode; wgap_mode = wmode; widx = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_name = name; cmd_addr = addr; cmd_len = LW'(len);
    @(posedge CLOCK_50); #1;
    cmd_valid = 1'b0;
    timed_out = 1'b1; got_err = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLOCK_50);
      if (done) begin
        got_err = err; timed_out = 1'b0;
        break;
      end
    end
    @(negedge CLOCK_50);
  endtask

  task automatic check_all(input string tag, input logic xerr, input int xbusy);
    chk({tag, "_timeout"}, int'(timed_out), 0);
    chk({tag, "_err"}, int'(got_err), int'(xerr));
    if (xbusy >= 0) chk({tag, "_busy"}, m_busy, xbusy);
    chk_q({tag, "_rden_addr"}, m_rden_a, e_rden);
    chk_q({tag, "_rd_data"}, m_rd_d, e_rd);
    chk_q({tag, "_wr_addr"}, m_wr_a, e_wa);
    chk_q({tag, "_wr_data"}, m_wr_d, e_wd);
    chk_q({tag, "_filename"}, m_fname, e_fn);
    chk({tag, "_del"}, m_del, e_del);
    chk({tag, "_exclusive_credit"}, m_viol, 0);
    if (timed_out) begin
      @(posedge CLOCK_50); #1 reset_n = 1'b0;
      @(posedge CLOCK_50); #1 reset_n = 1'b1;
      mdl_opened = 1'b0;
    end
  endtask

  typedef struct {
    logic [1:0]      op;
    logic [NB*8-1:0] name;
    logic [31:0]     addr;
    int              len;
    int              rmode;
    int              wmode;
    logic [31:0]     wbase;
    logic            exp_err;
    int              exp_busy;
  } vec_t;

  vec_t vt[11];

  initial begin
    logic [NB*8-1:0] longname, abname, rname;
    int zpos, r, len;
    logic [1:0] op;
    logic [31:0] addr;

    abname = '0;
    abname[63:0] = 64'h0000_7478_742E_6261;
    for (int k = 0; k < NB; k++) longname[8*k +: 8] = 8'(8'h41 + k);

    vt[0]  = '{2'd1, '0,       32'd5,         3, 0, 0, 32'h0, 1'b1, 2};
    vt[1]  = '{2'd2, '0,       32'd0,         1, 0, 0, 32'h1, 1'b1, 2};
    vt[2]  = '{2'd0, abname,   32'd0,         0, 0, 0, 32'h0, 1'b0, 3};
    vt[3]  = '{2'd1, '0,       32'd5,         3, 0, 0, 32'h0, 1'b0, -1};
    vt[4]  = '{2'd1, '0,       32'd100,       4, 1, 0, 32'h0, 1'b0, -1};
    vt[5]  = '{2'd2, '0,       32'hFFFF_FFFF, 2, 0, 1, 32'hA, 1'b0, -1};
    vt[6]  = '{2'd1, '0,       32'd0,         0, 0, 0, 32'h0, 1'b0, 2};
    vt[7]  = '{2'd1, '0,       32'hFFFF_FFFE, 3, 2, 0, 32'h0, 1'b0, -1};
    vt[8]  = '{2'd0, longname, 32'd0,         0, 0, 0, 32'h0, 1'b0, NW + 2};
    vt[9]  = '{2'd3, '0,       32'd0,         0, 0, 0, 32'h0, 1'b0, 2};
    vt[10] = '{2'd2, '0,       32'd9,         1, 0, 0, 32'h5, 1'b1, 2};

    repeat (2) @(negedge CLOCK_50);
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_strobes", int'({fs_rden, fs_wren, fs_del, rd_valid, wr_ready}), 0);
    chk("reset_filename", int'(fs_filename != 0), 0);
    @(posedge CLOCK_50); #1 reset_n = 1'b1;

    for (int k = 0; k < 11; k++) begin
      wq.delete();
      for (int i = 0; i < vt[k].len; i++) wq.push_back(vt[k].wbase + 32'(i));
      model(vt[k].op, vt[k].name, vt[k].addr, vt[k].len);
      run_cmd(vt[k].op, vt[k].name, vt[k].addr, vt[k].len, vt[k].rmode, vt[k].wmode);
      check_all($sformatf("v%0d", k), vt[k].exp_err, vt[k].exp_busy);
      if (k == 3) begin
        chk("v3_rd_latency", m_first_rd - m_first_rden, 2);
        chk("v3_rden_back_to_back", m_last_rden - m_first_rden, 2);
      end
    end

    // Reset while streaming a name: engine returns to idle and forgets the open.
    wq.delete();
    @(posedge CLOCK_50); #1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_name = longname;
    @(posedge CLOCK_50); #1 cmd_valid = 1'b0;
    @(negedge CLOCK_50);
    chk("midname_streaming", int'(fs_filename != 0), 1);
    @(posedge CLOCK_50); #1 reset_n = 1'b0;
    @(negedge CLOCK_50);
    chk("midname_rst_filename", int'(fs_filename), 0);
    chk("midname_rst_idle", int'({cmd_ready, busy}), 2);
    @(posedge CLOCK_50); #1 reset_n = 1'b1;
    mdl_opened = 1'b0;
    model(2'd1, '0, 32'd3, 1);
    run_cmd(2'd1, '0, 32'd3, 1, 0, 0);
    check_all("midname_read", e_err, e_busy);

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      op = (r < 2) ? 2'd0 : (r < 5) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      zpos = $urandom_range(0, 40);
      for (int k = 0; k < NB; k++) begin
        rname[8*k +: 8] = (k == zpos) ? 8'h00 :
                          (k < zpos) ? 8'($urandom_range(1, 255)) : 8'($urandom_range(0, 255));
      end
      addr = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : 32'($urandom);
      len = $urandom_range(0, 6);
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back(32'($urandom));
      model(op, rname, addr, len);
      run_cmd(op, rname, addr, len, 2, 2);
      check_all($sformatf("rnd%0d", t), e_err, e_busy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fs_request_engine.md
# fs_request_engine

Initiator for the filesystem word interface: accepts one file command at a time (open, read burst, write burst, delete) and drives `filename`/`rden`/`wren`/`del`/`address`/`data`, capturing `q`. Sits between the CPU load/store/syscall path and the filesystem responder. It converts a packed null-terminated name into the 4-byte-per-cycle name stream and sequences multi-word transfers with flow control on both sides.

## Interface
- `NAME_BYTES`, 32: capacity of `cmd_name` in bytes; must be a multiple of 4.
- `LEN_W`, 16: width of `cmd_len`.
- `CLOCK_50`  in  1  sole clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid` / `cmd_ready`  in / out  1 / 1  command handshake; transfer when both high.
- `cmd_op`  in  2  0 OPEN, 1 READ, 2 WRITE, 3 DELETE.
- `cmd_name`  in  NAME_BYTES*8  name, byte k at bits [8k+7:8k], null-terminated; used by OPEN only.
- `cmd_addr`  in  32  starting word address (READ/WRITE).
- `cmd_len`  in  LEN_W  word count (READ/WRITE).
- `rd_valid` / `rd_ready` / `rd_data`  out / in / out  1 / 1 / 32  read-data stream.
- `wr_valid` / `wr_ready` / `wr_data`  in / out / in  1 / 1 / 32  write-data stream.
- `done`  out  1  one-cycle pulse when a command retires.
- `err`  out  1  valid with `done`: READ/WRITE issued with no file open.
- `busy`  out  1  high from command accept until `done`.
- `fs_filename`  out  32  name stream word; 0 when not streaming.
- `fs_rden`, `fs_wren`, `fs_del`  out  1 each  responder strobes.
- `fs_address`, `fs_data`  out  32 each  word address / write data.
- `fs_q`  in  32  responder read data.

## Operation
- States: IDLE, NAME, READ, WRITE, DEL, DRAIN, DONE.
- IDLE: `cmd_ready`=1; accept latches op/name/addr/len; next state by op.
- NAME: emit word i = `cmd_name[32i+31:32i]` per cycle; the word containing the first zero byte is the last one emitted. If no zero byte in NAME_BYTES, emit one extra all-zero word. Set `opened` flag; → DONE.
- READ: if `!opened` → DONE with `err`. Else issue `fs_rden` with `fs_address`=addr, addr+1, … while credits allow (FIFO occupancy + in-flight < 2). After `cmd_len` issues → DRAIN.
- DRAIN: wait until in-flight = 0 and FIFO empty → DONE.
- WRITE: if `!opened` → DONE with `err`. `wr_ready`=1 in WRITE; on `wr_valid&wr_ready` drive `fs_wren`, `fs_data`=`wr_data`, `fs_address`=current addr that cycle (combinational pass-through, registered outputs not required). After `cmd_len` beats → DONE.
- DEL: `fs_del`=1 for one cycle, clear `opened` → DONE.
- DONE: `done`=1 one cycle (`err` if applicable) → IDLE.
- `cmd_len`=0: no bus activity; READ/WRITE → DONE directly.
- Address arithmetic modulo 2^32 (0xFFFFFFFF wraps to 0).
- `fs_rden`, `fs_wren`, `fs_del`, nonzero `fs_filename` mutually exclusive in every cycle.

## Timing
- Reset: state IDLE, all outputs 0 except `cmd_ready`=1; `opened`=0; FIFO and in-flight counter cleared.
- Responder read latency 1: `fs_q` valid the cycle after `fs_rden`; captured into FIFO that edge.
- Sustained read rate 1 word/cycle with `rd_ready`=1; `rd_data` appears 2 cycles after first `fs_rden` cycle (capture + FIFO output).
- Simultaneous FIFO push/pop when full-1 permitted.
- OPEN of an n-word name: busy n+1 cycles (n stream + DONE).
- DEL: busy 2 cycles.
- Reset mid-NAME leaves the responder holding a partial name; responder must be reset with it. The engine emits no flush word.

## Structure
- Package `fs_pkg`: `fs_op_t` enum (OPEN/READ/WRITE/DELETE), state enum, `FS_WORD_W`=32.
- Sub-module `fs_rd_fifo`: 2-entry, 32-bit, valid/ready both sides, async active-low reset.

## Test plan
- OPEN "ab.txt\0" → `fs_filename` 0x742E6261, 0x00007478 on consecutive cycles, then 0; `done` next cycle.
- READ addr 5 len 3, `rd_ready`=1, model returns addr*4 → `fs_address` 5,6,7 on consecutive cycles; `rd_data` 20,24,28; one `done`.
- READ len 4 with `rd_ready` toggling 1/0 → no word lost or duplicated; `fs_rden` never leaves >2 outstanding.
- WRITE addr 0xFFFFFFFF len 2, data 0xA, 0xB with one-cycle `wr_valid` gap → writes at 0xFFFFFFFF then 0x0; `done` after second beat.
- READ after reset with no OPEN → no `fs_rden`; `done`=`err`=1 same cycle.
- DELETE then WRITE len 1 → `fs_del` one cycle; WRITE retires with `err`=1, no `fs_wren`.
